// File: rtl/gesture_uart_rx.sv
// UART receiver for host gesture frames: SYNC_BYTE, code[, ~code] -> held gesture code with link-loss timeout.
// Build option GESTURE_CSUM_EN selects the 3-byte checksummed frame; undefined gives the 2-byte frame.
module gesture_uart_rx #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter int unsigned TIMEOUT_MS = 500,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] gesture,
    output logic       gesture_valid,
    output logic       frame_err,
    output logic       link_alive
);

    localparam int unsigned CLKS_PER_BIT   = CLK_HZ / BAUD;
    localparam int unsigned TIMEOUT_CYCLES = (CLK_HZ / 1000) * TIMEOUT_MS;
    localparam int unsigned CNT_W          = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned TO_W           = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        BIT_IDLE,
        BIT_START,
        BIT_DATA,
        BIT_STOP
    } bit_state_e;

`ifdef GESTURE_CSUM_EN
    typedef enum logic [1:0] {
        WAIT_SYNC,
        WAIT_CODE,
        WAIT_CSUM
    } parse_state_e;
`else
    typedef enum logic [1:0] {
        WAIT_SYNC,
        WAIT_CODE
    } parse_state_e;
`endif

    // Input synchronizer; flops reset to the idle level so no false start edge follows reset.
    logic rx_meta_q, rx_sync_q, rx_prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    bit_state_e       bit_state_q, bit_state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       byte_q, byte_d;
    logic             byte_done_q, byte_done_d;
    logic             stop_err_q, stop_err_d;

    always_comb begin
        bit_state_d = bit_state_q;
        bit_cnt_d   = bit_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        byte_d      = byte_q;
        byte_done_d = 1'b0;
        stop_err_d  = 1'b0;
        unique case (bit_state_q)
            BIT_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    bit_state_d = BIT_START;
                    bit_cnt_d   = '0;
                end
            end
            BIT_START: begin
                if (bit_cnt_q == HALF_LAST) begin
                    bit_cnt_d   = '0;
                    bit_idx_d   = '0;
                    bit_state_d = rx_sync_q ? BIT_IDLE : BIT_DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            BIT_DATA: begin
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        bit_state_d = BIT_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            BIT_STOP: begin
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d   = '0;
                    bit_state_d = BIT_IDLE;
                    if (rx_sync_q) begin
                        byte_done_d = 1'b1;
                        byte_d      = shift_q;
                    end else begin
                        stop_err_d = 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            default: bit_state_d = BIT_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_state_q <= BIT_IDLE;
            bit_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            byte_q      <= '0;
            byte_done_q <= 1'b0;
            stop_err_q  <= 1'b0;
        end else begin
            bit_state_q <= bit_state_d;
            bit_cnt_q   <= bit_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            byte_q      <= byte_d;
            byte_done_q <= byte_done_d;
            stop_err_q  <= stop_err_d;
        end
    end

    parse_state_e    parse_state_q, parse_state_d;
    logic [7:0]      gesture_q, gesture_d;
    logic            gesture_valid_q, gesture_valid_d;
    logic            frame_err_q, frame_err_d;
    logic            link_alive_q, link_alive_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            accept;
    logic [7:0]      accept_code;
`ifdef GESTURE_CSUM_EN
    logic [7:0]      code_q, code_d;
`endif

    function automatic logic code_in_range(input logic [7:0] c);
        return (c >= 8'h01) && (c <= 8'h03);
    endfunction

    always_comb begin
        parse_state_d   = parse_state_q;
        gesture_d       = gesture_q;
        gesture_valid_d = 1'b0;
        frame_err_d     = 1'b0;
        link_alive_d    = link_alive_q;
        to_cnt_d        = to_cnt_q;
        accept          = 1'b0;
        accept_code     = '0;
`ifdef GESTURE_CSUM_EN
        code_d          = code_q;
`endif

        if (link_alive_q) begin
            if (to_cnt_q == TO_LAST) begin
                link_alive_d = 1'b0;
                gesture_d    = '0;
                to_cnt_d     = '0;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end

        if (stop_err_q) begin
            frame_err_d   = 1'b1;
            parse_state_d = WAIT_SYNC;
        end else if (byte_done_q) begin
            unique case (parse_state_q)
                WAIT_SYNC: begin
                    if (byte_q == SYNC_BYTE) parse_state_d = WAIT_CODE;
                end
                WAIT_CODE: begin
                    if (byte_q != SYNC_BYTE) begin
`ifdef GESTURE_CSUM_EN
                        code_d        = byte_q;
                        parse_state_d = WAIT_CSUM;
`else
                        parse_state_d = WAIT_SYNC;
                        if (code_in_range(byte_q)) begin
                            accept      = 1'b1;
                            accept_code = byte_q;
                        end else begin
                            frame_err_d = 1'b1;
                        end
`endif
                    end
                end
`ifdef GESTURE_CSUM_EN
                WAIT_CSUM: begin
                    parse_state_d = WAIT_SYNC;
                    if ((byte_q == ~code_q) && code_in_range(code_q)) begin
                        accept      = 1'b1;
                        accept_code = code_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
`endif
                default: parse_state_d = WAIT_SYNC;
            endcase
        end

        // An accept overrides a timeout expiring in the same cycle.
        if (accept) begin
            gesture_d       = accept_code;
            gesture_valid_d = 1'b1;
            link_alive_d    = 1'b1;
            to_cnt_d        = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parse_state_q   <= WAIT_SYNC;
            gesture_q       <= '0;
            gesture_valid_q <= 1'b0;
            frame_err_q     <= 1'b0;
            link_alive_q    <= 1'b0;
            to_cnt_q        <= '0;
`ifdef GESTURE_CSUM_EN
            code_q          <= '0;
`endif
        end else begin
            parse_state_q   <= parse_state_d;
            gesture_q       <= gesture_d;
            gesture_valid_q <= gesture_valid_d;
            frame_err_q     <= frame_err_d;
            link_alive_q    <= link_alive_d;
            to_cnt_q        <= to_cnt_d;
`ifdef GESTURE_CSUM_EN
            code_q          <= code_d;
`endif
        end
    end

    assign gesture       = gesture_q;
    assign gesture_valid = gesture_valid_q;
    assign frame_err     = frame_err_q;
    assign link_alive    = link_alive_q;

endmodule
